rom_loader: RTL
===============

Name: rom_loader

Overview:
- Boot-time programmer that sits directly upstream of the instruction ROM.
- Consumes a byte stream from the UART receiver and assembles little-endian 32-bit instruction words.
- Drives the ROM write port (wr_en/addr/data) to store those words.
- Holds the CPU core in reset while loading, and reports completion or error.

Parameters:
- ROM_NUM, 4096, ROM depth in words; a word count above this is an error.
- TIMEOUT_CYC, 1000000, maximum idle clocks between bytes during a load before aborting.
- CNT_W, 16, width of the word-count field and internal word counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- load_req  input  1  single-cycle pulse that starts a load; ignored while busy.
- rx_valid  input  1  single-cycle strobe; rx_data is valid this cycle; no backpressure.
- rx_data  input  8  received byte.
- wr_en  output  1  ROM write enable, one-cycle pulse per word.
- addr  output  32  ROM byte address (`INST_ADDR_BUS), word-aligned.
- data_o  output  32  ROM write data (`INST_DATA_BUS).
- cpu_hold  output  1  high while loading; holds the core in reset.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky error flag; cleared by the next accepted load_req.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- Reset asserted mid-load aborts immediately with no further writes.
- States:
  - IDLE: waits for load_req. On load_req, clears err, byte index, word index and timeout counter, then goes to LEN.
  - LEN: takes 2 bytes as the word count N, low byte first.
    - N > ROM_NUM goes to ERR.
    - N == 0 goes to DONE.
    - Otherwise goes to DATA.
  - DATA: shifts bytes into a 32-bit assembly register. Byte 0 goes to bits [7:0], byte 3 to bits [31:24].
  - Word write: on the 4th byte, the word is latched to data_o and addr = word_idx<<2. wr_en pulses high on the following cycle only. word_idx increments with the pulse.
    - data_o and addr stay stable until the next write.
    - The FSM stays in DATA during the wr_en cycle and can accept a new byte in that same cycle.
  - Last word: when the pulse writes word N-1, go to DONE (or CSUM if enabled).
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err=1 (sticky), then IDLE.
- cpu_hold = 1 in LEN, DATA, CSUM and DONE. It is 0 in IDLE and ERR, so the core is released the same cycle done pulses ends.
- Timeout:
  - The counter resets on each rx_valid and increments every cycle in LEN, DATA and CSUM.
  - Reaching TIMEOUT_CYC-1 goes to ERR.
  - A partially assembled word is never written.
- load_req while busy is ignored.
- rx_valid in IDLE is ignored.
- load_req together with rx_valid in IDLE: the load starts, and that byte is not consumed.
- Word index width is CNT_W+1, so N == ROM_NUM completes without wrap. The highest address written is (ROM_NUM-1)*4.

Optional Feature:
- Macro: ROM_LOADER_CSUM_EN.
- When defined:
  - After the last word, the FSM enters CSUM and takes one byte.
  - That byte is compared with the XOR of all received data bytes (length bytes excluded).
  - Match goes to DONE; mismatch goes to ERR. Words are already written either way; err flags a corrupt image.
- When undefined: no CSUM state and no XOR accumulator; the last word goes straight to DONE.

Test Plan:
- load_req; bytes 02 00, 93 00 10 F0, 13 01 40 00 -> exactly two wr_en pulses: addr 0x0/data 0xF0100093, then addr 0x4/data 0x00400113. done pulses once, cpu_hold falls, err=0.
- load_req; count bytes 00 00 -> no wr_en; done pulses within 2 cycles of the 2nd byte; cpu_hold high only during LEN/DONE.
- ROM_NUM=16; count bytes 11 00 (N=17) -> err=1, no wr_en, cpu_hold=0. A following valid load_req clears err.
- TIMEOUT_CYC=100; count 01 00 then only 2 data bytes -> err=1 after 100 idle cycles, no wr_en, FSM in IDLE.
- Second load_req mid-load, plus reset asserted after the 2nd word -> the extra load_req has no effect. Reset clears all outputs within the same cycle, and no further wr_en follows.
- With ROM_LOADER_CSUM_EN: N=1, data 01 02 03 04, csum 04 -> done=1. Same data with csum 05 -> err=1; the word 0x04030201 is still written to addr 0x0.

Source files
------------

// File: rtl/rom_loader.sv
// Boot-time ROM programmer: assembles a length-prefixed little-endian byte stream into
// 32-bit words, writes them to the instruction ROM and holds the core in reset meanwhile.
// Optional trailing XOR checksum byte is enabled by defining ROM_LOADER_CSUM_EN.
module rom_loader #(
  parameter int ROM_NUM     = 4096,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr_en,
  output logic [31:0] addr,
  output logic [31:0] data_o,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int IDX_W = CNT_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W:0]   ROM_MAX  = (CNT_W+1)'(ROM_NUM);

`ifdef ROM_LOADER_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_e;
`endif

  state_e             state_q, state_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_w;
  logic [31:0]        asm_q, asm_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy, tmo_hit;
`ifdef ROM_LOADER_CSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  assign busy    = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef ROM_LOADER_CSUM_EN
                || (state_q == S_CSUM)
`endif
                ;
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign len_w   = CNT_W'({rx_data, cnt_q[7:0]});

  always_comb begin
    // NOTE: every _d gets a default here so no path can leave a latch behind.
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    tmo_d      = tmo_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
`ifdef ROM_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif
    if (busy) tmo_d = rx_valid ? '0 : tmo_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        // A byte arriving alongside load_req is deliberately not consumed.
        if (load_req) begin
          state_d    = S_LEN;
          err_d      = 1'b0;
          byte_idx_d = '0;
          word_idx_d = '0;
          cnt_d      = '0;
          tmo_d      = '0;
`ifdef ROM_LOADER_CSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (byte_idx_q == 2'd0) begin
            cnt_d[7:0] = rx_data;
            byte_idx_d = 2'd1;
          end else begin
            cnt_d      = len_w;
            byte_idx_d = '0;
            if ({1'b0, len_w} > ROM_MAX) state_d = S_ERR;
            else if (len_w == '0)        state_d = S_DONE;
            else                         state_d = S_DATA;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
      S_DATA: begin
`ifndef ROM_LOADER_CSUM_EN
        if (wr_en_q && (word_idx_q == {1'b0, cnt_q})) begin
          state_d = S_DONE;
        end else
`endif
        if (rx_valid) begin
`ifdef ROM_LOADER_CSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            data_d     = {rx_data, asm_q[23:0]};
            addr_d     = 32'({word_idx_q, 2'b00});
            wr_en_d    = 1'b1;
            word_idx_d = word_idx_q + 1'b1;
            byte_idx_d = '0;
`ifdef ROM_LOADER_CSUM_EN
            if (word_idx_d == {1'b0, cnt_q}) state_d = S_CSUM;
`endif
          end else begin
            asm_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end
      end
`ifdef ROM_LOADER_CSUM_EN
      S_CSUM: begin
        if (rx_valid)     state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        else if (tmo_hit) state_d = S_ERR;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR) err_d = 1'b1;
    done_d     = (state_d == S_DONE);
    cpu_hold_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_DONE)
`ifdef ROM_LOADER_CSUM_EN
              || (state_d == S_CSUM)
`endif
              ;
  end

  // NOTE: datapath registers are reset too, so a mid-load reset leaves no stale addr/data on the ROM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      cnt_q      <= '0;
      asm_q      <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ROM_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      tmo_q      <= tmo_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef ROM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign wr_en    = wr_en_q;
  assign addr     = addr_q;
  assign data_o   = data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
